// File: rtl/ripple_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
// Sub-modules and the top import this package so the default width has one home.
package ripple_adder_pkg;

    localparam int ADDER_WIDTH = 4;

endpackage : ripple_adder_pkg

// File: rtl/full_adder.sv
// One-bit full-adder cell: the repeating element of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic halfSum;

    assign halfSum = a ^ b;
    assign s       = halfSum ^ cin;
    assign cout    = (a & b) | (cin & halfSum);

endmodule : full_adder

// File: rtl/ripple_adder.sv
// Unsigned WIDTH-bit ripple-carry adder with carry-in/carry-out.
// The result is registered, so the block has a one-cycle latency.
module ripple_adder
    import ripple_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic [WIDTH-1:0] SUM,
    output logic             CO
);

    logic [WIDTH-1:0] sumBits;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             co_d, co_q;

    // Each stage keeps its own carry signal rather than sharing one packed
    // vector, so the chain stays free of self-referencing combinational nets.
    for (genvar i = 0; i < WIDTH; i++) begin : stage
        logic cin;
        logic cout;

        if (i == 0) begin : g_first
            assign cin = CI;
        end else begin : g_chain
            assign cin = stage[i-1].cout;
        end

        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (cin),
            .s    (sumBits[i]),
            .cout (cout)
        );
    end

    assign sum_d = sumBits;
    assign co_d  = stage[WIDTH-1].cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            co_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            co_q  <= co_d;
        end
    end

    assign SUM = sum_q;
    assign CO  = co_q;

endmodule : ripple_adder

// File: tb/tb_ripple_adder.sv
// Scoreboard bench for ripple_adder at WIDTH=4 (exhaustive) and WIDTH=8 (random),
// both fed every cycle and compared against plain integer addition.
module tb_ripple_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a4, b4;
    logic       ci4;
    logic [3:0] sum4;
    logic       co4;
    logic [7:0] a8, b8;
    logic       ci8;
    logic [7:0] sum8;
    logic       co8;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;

    typedef struct {
        int         due;
        bit         wide;
        logic [8:0] exp;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
    } sbEntry_t;

    sbEntry_t sb[$];

    ripple_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a4),
        .B     (b4),
        .CI    (ci4),
        .SUM   (sum4),
        .CO    (co4)
    );

    ripple_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a8),
        .B     (b8),
        .CI    (ci8),
        .SUM   (sum8),
        .CO    (co8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] req);
        nChecks++;
        if (act === req) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Reference model: the adder is just integer addition; keep WIDTH+1 bits.
    task automatic pushExpected(input bit wide, input logic [7:0] a, input logic [7:0] b, input logic ci);
        sbEntry_t e;
        int total;
        total  = int'(a) + int'(b) + int'(ci);
        e.due  = cyc + 1;
        e.wide = wide;
        e.exp  = total[8:0];
        e.a    = a;
        e.b    = b;
        e.ci   = ci;
        sb.push_back(e);
    endtask

    // Drive both DUTs just after a rising edge; the result lands on the next edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic ci);
        @(posedge clk);
        #1;
        a4  = a;
        b4  = b;
        ci4 = ci;
        a8  = 8'($urandom_range(255));
        b8  = 8'($urandom_range(255));
        ci8 = 1'($urandom_range(1));
        pushExpected(1'b0, {4'h0, a}, {4'h0, b}, ci);
        pushExpected(1'b1, a8, b8, ci8);
    endtask

    // Monitor: the output register updates on every edge, so each entry is
    // compared on the falling edge of the cycle it is due in.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sbEntry_t e;
            logic [8:0] act;
            e = sb.pop_front();
            if (e.due < cyc) begin
                checkOutput("late_entry", 9'h1ff, 9'h000);
            end else if (e.wide) begin
                act = {co8, sum8};
                checkOutput($sformatf("add8 %h+%h+%0d", e.a, e.b, e.ci), act, e.exp);
            end else begin
                act = {4'h0, co4, sum4};
                checkOutput($sformatf("add4 %h+%h+%0d", e.a[3:0], e.b[3:0], e.ci), act, e.exp);
            end
        end
    end

    initial begin
        logic [8:0] v;

        rst_n = 1'b0;
        a4 = 4'hf; b4 = 4'hf; ci4 = 1'b1;
        a8 = 8'hff; b8 = 8'hff; ci8 = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("reset_hold4", {4'h0, co4, sum4}, 9'h000);
            checkOutput("reset_hold8", {co8, sum8}, 9'h000);
        end

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pushExpected(1'b0, 8'h0f, 8'h0f, 1'b1);
        pushExpected(1'b1, 8'hff, 8'hff, 1'b1);

        applyStimulus(4'h0, 4'h0, 1'b0);
        applyStimulus(4'h1, 4'h2, 1'b0);
        applyStimulus(4'h5, 4'h3, 1'b1);
        applyStimulus(4'hf, 4'h1, 1'b0);
        applyStimulus(4'ha, 4'h5, 1'b1);
        applyStimulus(4'hf, 4'hf, 1'b1);

        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            applyStimulus(v[3:0], v[7:4], v[8]);
        end

        applyStimulus(4'h7, 4'h1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset4", {4'h0, co4, sum4}, 9'h000);
        checkOutput("async_reset8", {co8, sum8}, 9'h000);
        @(posedge clk);
        #1;
        checkOutput("reset_over_edge4", {4'h0, co4, sum4}, 9'h000);
        rst_n = 1'b1;
        #1;
        checkOutput("no_stale_after_release4", {4'h0, co4, sum4}, 9'h000);
        checkOutput("no_stale_after_release8", {co8, sum8}, 9'h000);

        applyStimulus(4'h3, 4'h4, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
        end

        for (int n = 0; n < 10 && sb.size() > 0; n++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            nChecks++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule : tb_ripple_adder
